// File: rtl/seq_div32.sv
// rtl/seq_div32.sv - sequential 32-bit signed/unsigned restoring divider
// One quotient bit per cycle; sign handling wraps an unsigned magnitude core.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOT,
    output logic [WIDTH-1:0] REM,
    output logic             DIVZ
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_raw;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_o;
    logic             r_divz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Conditional two's-complement negate; serves both for magnitudes and result fix-up.
    function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] x, input logic n);
        f_cneg = (x ^ {WIDTH{n}}) + {{(WIDTH-1){1'b0}}, n};
    endfunction

    assign w_dvd_neg = SIGNED & DIVIDEND[WIDTH-1];
    assign w_dvs_neg = SIGNED & DIVISOR[WIDTH-1];
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem_o   <= '0;
            r_divz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_dvd_raw <= DIVIDEND;
                        r_quo     <= f_cneg(DIVIDEND, w_dvd_neg);
                        r_dvs     <= f_cneg(DIVISOR, w_dvs_neg);
                        r_rem     <= '0;
                        r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r   <= w_dvd_neg;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_dz      <= (DIVISOR == '0);
                        // A zero divisor bypasses the iteration and completes on the next edge.
                        r_state   <= (DIVISOR == '0) ? FIX : ITER;
                    end
                end
                ITER: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_quot  <= '1;
                        r_rem_o <= r_dvd_raw;
                        r_divz  <= 1'b1;
                    end else begin
                        r_quot  <= f_cneg(r_quo, r_neg_q);
                        r_rem_o <= f_cneg(r_rem, r_neg_r);
                        r_divz  <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign QUOT = r_quot;
    assign REM  = r_rem_o;
    assign DIVZ = r_divz;

endmodule

// File: tb/tb_seq_div32.sv
// tb/tb_seq_div32.sv - directed vector bench for seq_div32
module tb_seq_div32;
    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        SIGNED;
    logic [31:0] DIVIDEND;
    logic [31:0] DIVISOR;
    logic        BUSY;
    logic        DONE;
    logic [31:0] QUOT;
    logic [31:0] REM;
    logic        DIVZ;

    int n_tests = 0;
    int n_fail  = 0;

    seq_div32 #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED),
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .BUSY(BUSY), .DONE(DONE), .QUOT(QUOT), .REM(REM), .DIVZ(DIVZ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        sgn;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives a request for one edge, then scrambles the operand inputs.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        START    = 1'b1;
        SIGNED   = s;
        DIVIDEND = a;
        DIVISOR  = b;
        tick();
        START    = 1'b0;
        SIGNED   = ~s;
        DIVIDEND = $urandom;
        DIVISOR  = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!DONE && lat < 100) begin
            if (BUSY) busy_cnt++;
            tick();
            lat++;
        end
        if (!DONE) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE after %0d cycles, expected DONE", lat);
        end
    endtask

    vec_t vecs[13];
    int   lat;
    int   bc;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33};
        vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
        vecs[6]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};
        vecs[7]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
        vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33};
        vecs[11] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33};
        vecs[12] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1, 1};

        RST = 1'b1; START = 1'b0; SIGNED = 1'b0; DIVIDEND = '0; DIVISOR = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_quot", QUOT, 32'd0);
        chk("rst_rem",  REM,  32'd0);
        chk("rst_divz", {31'd0, DIVZ}, 32'd0);

        // Each request is issued in the DONE cycle of the previous one.
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs);
            wait_done(lat, bc);
            chk($sformatf("v%0d_quot", i), QUOT, vecs[i].q);
            chk($sformatf("v%0d_rem", i), REM, vecs[i].r);
            chk($sformatf("v%0d_divz", i), {31'd0, DIVZ}, {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat);
        end
        tick();
        chk("done_one_pulse", {31'd0, DONE}, 32'd0);

        // Reset mid-operation, asserted together with START.
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        chk("abort_no_done", {31'd0, DONE}, 32'd0);
        RST = 1'b1; START = 1'b1; DIVIDEND = 32'd8; DIVISOR = 32'd2;
        tick();
        RST = 1'b0; START = 1'b0;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_quot", QUOT, 32'd0);
        chk("abort_rem",  REM,  32'd0);
        chk("abort_divz", {31'd0, DIVZ}, 32'd0);
        tick();
        chk("abort_idle_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_idle_done", {31'd0, DONE}, 32'd0);
        issue(1'b0, 32'd50, 32'd5);
        wait_done(lat, bc);
        chk("post_rst_latency", lat, 33);
        chk("post_rst_quot", QUOT, 32'd10);
        chk("post_rst_rem",  REM,  32'd0);

        // START while busy is ignored; START with DONE is accepted.
        issue(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        START = 1'b1; DIVIDEND = 32'd1; DIVISOR = 32'd1;
        tick();
        START = 1'b0;
        wait_done(lat, bc);
        chk("busy_start_latency", lat, 28);
        chk("busy_start_quot", QUOT, 32'd14);
        chk("busy_start_rem",  REM,  32'd2);
        issue(1'b0, 32'd1, 32'd1);
        wait_done(lat, bc);
        chk("b2b_latency", lat, 33);
        chk("b2b_quot", QUOT, 32'd1);
        chk("b2b_rem",  REM,  32'd0);
        tick();
        chk("final_idle_busy", {31'd0, BUSY}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
